pa_iu_ex2_wb_buf: RTL and testbench



---
 rtl/pa_iu_ex2_wb_buf_pkg.sv | 16 +
 rtl/pa_iu_wb_fifo.sv | 76 +++++++
 rtl/pa_iu_ex2_wb_buf.sv | 126 ++++++++++++
 tb/tb_pa_iu_ex2_wb_buf.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_iu_ex2_wb_buf_pkg.sv
// Shared IU definitions for the EX2 write-back buffer: widths and the
// buffered write-back entry layout.
package pa_iu_ex2_wb_buf_pkg;

  localparam int IU_XLEN      = 32;
  localparam int IU_REG_IDX_W = 5;

  typedef struct packed {
    logic                    vld;
    logic [IU_REG_IDX_W-1:0] rd;
    logic [IU_XLEN-1:0]      data;
  } iu_wb_entry_t;

  localparam int IU_WB_ENTRY_W = 1 + IU_REG_IDX_W + IU_XLEN;

endpackage

// File: rtl/pa_iu_wb_fifo.sv
// DEPTH-entry circular FIFO of deferred multiply write-backs; the whole
// entry array is exported flattened so the parent can run a forwarding CAM.
module pa_iu_wb_fifo
  import pa_iu_ex2_wb_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  iu_wb_entry_t                   push_entry,
  input  logic                           pop,
  output logic [PTR_W-1:0]               head_ptr,
  output logic [PTR_W-1:0]               tail_ptr,
  output logic [CNT_W-1:0]               count,
  output logic [DEPTH*IU_WB_ENTRY_W-1:0] entries_flat
);

  iu_wb_entry_t     entry_q [DEPTH];
  iu_wb_entry_t     entry_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push is applied after pop; the parent never pushes into a full FIFO,
  // so the two never target the same slot.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      entry_d[head_q].vld = 1'b0;
      head_d              = ptr_inc(head_q);
    end
    if (push) begin
      entry_d[tail_q]     = push_entry;
      entry_d[tail_q].vld = 1'b1;
      tail_d              = ptr_inc(tail_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign entries_flat[g*IU_WB_ENTRY_W +: IU_WB_ENTRY_W] = entry_q[g];
  end

  assign head_ptr = head_q;
  assign tail_ptr = tail_q;
  assign count    = count_q;

endmodule

// File: rtl/pa_iu_ex2_wb_buf.sv
// EX2 multiply write-back buffer: arbitrates the integer RF write port
// (LSU first, then buffered multiplies, then direct multiply) and forwards
// pending multiply results.
module pa_iu_ex2_wb_buf
  import pa_iu_ex2_wb_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  input  logic                    mul_wb_ex2_vld,
  input  logic [IU_REG_IDX_W-1:0] mul_wb_ex2_rd,
  input  logic [IU_XLEN-1:0]      mul_wb_ex2_data,
  input  logic                    lsu_wb_vld,
  input  logic [IU_REG_IDX_W-1:0] lsu_wb_rd,
  input  logic [IU_XLEN-1:0]      lsu_wb_data,
  input  logic [IU_REG_IDX_W-1:0] fwd_rs_idx,
  output logic                    fwd_hit,
  output logic [IU_XLEN-1:0]      fwd_data,
  output logic                    wb_rf_wen,
  output logic [IU_REG_IDX_W-1:0] wb_rf_waddr,
  output logic [IU_XLEN-1:0]      wb_rf_wdata,
  output logic                    wb_xx_ex2_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]               head_ptr;
  logic [PTR_W-1:0]               tail_ptr;
  logic [CNT_W-1:0]               count;
  logic [DEPTH*IU_WB_ENTRY_W-1:0] entries_flat;
  iu_wb_entry_t                   ent [DEPTH];
  iu_wb_entry_t                   push_entry;
  logic                           push, pop;
  logic                           stall, buf_empty, mul_keep;

  logic                    wen_q, wen_d;
  logic [IU_REG_IDX_W-1:0] waddr_q, waddr_d;
  logic [IU_XLEN-1:0]      wdata_q, wdata_d;
  int                      fwd_slot;

  for (genvar g = 0; g < DEPTH; g++) begin : g_unflat
    assign ent[g] = entries_flat[g*IU_WB_ENTRY_W +: IU_WB_ENTRY_W];
  end

  assign stall     = (count == CNT_W'(DEPTH));
  assign buf_empty = (count == '0);
  // Writes to x0 are dropped at acceptance and never occupy the buffer.
  assign mul_keep  = mul_wb_ex2_vld && !stall && (mul_wb_ex2_rd != '0);
  assign push_entry = '{vld: 1'b1, rd: mul_wb_ex2_rd, data: mul_wb_ex2_data};

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (lsu_wb_vld) begin
      wen_d   = (lsu_wb_rd != '0);
      waddr_d = lsu_wb_rd;
      wdata_d = lsu_wb_data;
      push    = mul_keep;
    end else if (!buf_empty) begin
      pop     = 1'b1;
      wen_d   = 1'b1;
      waddr_d = ent[head_ptr].rd;
      wdata_d = ent[head_ptr].data;
      push    = mul_keep;
    end else if (mul_keep) begin
      wen_d   = 1'b1;
      waddr_d = mul_wb_ex2_rd;
      wdata_d = mul_wb_ex2_data;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  pa_iu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (forever_cpuclk),
    .rst          (cpurst),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .head_ptr     (head_ptr),
    .tail_ptr     (tail_ptr),
    .count        (count),
    .entries_flat (entries_flat)
  );

  // Walk oldest to youngest so the youngest match is the last to win;
  // the registered port is older than every buffered entry.
  always_comb begin
    fwd_hit  = wen_q && (waddr_q == fwd_rs_idx);
    fwd_data = fwd_hit ? wdata_q : '0;
    fwd_slot = 0;
    for (int k = DEPTH; k >= 1; k--) begin
      fwd_slot = int'(tail_ptr) - k;
      if (fwd_slot < 0) fwd_slot = fwd_slot + DEPTH;
      if (ent[PTR_W'(fwd_slot)].vld && (ent[PTR_W'(fwd_slot)].rd == fwd_rs_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent[PTR_W'(fwd_slot)].data;
      end
    end
    if (fwd_rs_idx == '0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  assign wb_rf_wen       = wen_q;
  assign wb_rf_waddr     = waddr_q;
  assign wb_rf_wdata     = wdata_q;
  assign wb_xx_ex2_stall = stall;

endmodule

// File: tb/tb_pa_iu_ex2_wb_buf.sv
// Bench for pa_iu_ex2_wb_buf: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pa_iu_ex2_wb_buf;

  localparam int DEPTH = 2;

  // clock / reset
  logic forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  logic        cpurst = 1'b1;
  logic        mul_wb_ex2_vld = 1'b0;
  logic [4:0]  mul_wb_ex2_rd = '0;
  logic [31:0] mul_wb_ex2_data = '0;
  logic        lsu_wb_vld = 1'b0;
  logic [4:0]  lsu_wb_rd = '0;
  logic [31:0] lsu_wb_data = '0;
  logic [4:0]  fwd_rs_idx = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        wb_rf_wen;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        wb_xx_ex2_stall;

  pa_iu_ex2_wb_buf #(.DEPTH(DEPTH)) dut (
    .forever_cpuclk  (forever_cpuclk),
    .cpurst          (cpurst),
    .mul_wb_ex2_vld  (mul_wb_ex2_vld),
    .mul_wb_ex2_rd   (mul_wb_ex2_rd),
    .mul_wb_ex2_data (mul_wb_ex2_data),
    .lsu_wb_vld      (lsu_wb_vld),
    .lsu_wb_rd       (lsu_wb_rd),
    .lsu_wb_data     (lsu_wb_data),
    .fwd_rs_idx      (fwd_rs_idx),
    .fwd_hit         (fwd_hit),
    .fwd_data        (fwd_data),
    .wb_rf_wen       (wb_rf_wen),
    .wb_rf_waddr     (wb_rf_waddr),
    .wb_rf_wdata     (wb_rf_wdata),
    .wb_xx_ex2_stall (wb_xx_ex2_stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pending multiplies in acceptance order + port register
  logic [4:0]  exp_q_rd[$];
  logic [31:0] exp_q_data[$];
  logic        exp_wen = 1'b0;
  logic [4:0]  exp_waddr = '0;
  logic [31:0] exp_wdata = '0;
  bit          model_on = 1'b0;
  logic        m_take;
  logic        m_hit;
  logic [31:0] m_data;

  always @(posedge forever_cpuclk) begin
    if (cpurst) begin
      exp_q_rd.delete();
      exp_q_data.delete();
      exp_wen   = 1'b0;
      exp_waddr = '0;
      exp_wdata = '0;
      model_on  = 1'b1;
    end else if (model_on) begin
      m_take = mul_wb_ex2_vld && (exp_q_rd.size() < DEPTH) && (mul_wb_ex2_rd != 0);
      if (lsu_wb_vld) begin
        exp_wen   = (lsu_wb_rd != 0);
        exp_waddr = lsu_wb_rd;
        exp_wdata = lsu_wb_data;
        if (m_take) begin
          exp_q_rd.push_back(mul_wb_ex2_rd);
          exp_q_data.push_back(mul_wb_ex2_data);
        end
      end else if (exp_q_rd.size() != 0) begin
        exp_wen   = 1'b1;
        exp_waddr = exp_q_rd.pop_front();
        exp_wdata = exp_q_data.pop_front();
        if (m_take) begin
          exp_q_rd.push_back(mul_wb_ex2_rd);
          exp_q_data.push_back(mul_wb_ex2_data);
        end
      end else if (m_take) begin
        exp_wen   = 1'b1;
        exp_waddr = mul_wb_ex2_rd;
        exp_wdata = mul_wb_ex2_data;
      end else begin
        exp_wen = 1'b0;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge forever_cpuclk) begin
    if (model_on) begin
      check("stall", wb_xx_ex2_stall, exp_q_rd.size() == DEPTH);
      check("wen", wb_rf_wen, exp_wen);
      if (exp_wen) begin
        check("waddr", wb_rf_waddr, exp_waddr);
        check("wdata", wb_rf_wdata, exp_wdata);
      end
      m_hit  = 1'b0;
      m_data = '0;
      for (int i = exp_q_rd.size() - 1; i >= 0; i--) begin
        if (!m_hit && exp_q_rd[i] == fwd_rs_idx) begin
          m_hit  = 1'b1;
          m_data = exp_q_data[i];
        end
      end
      if (!m_hit && exp_wen && exp_waddr == fwd_rs_idx) begin
        m_hit  = 1'b1;
        m_data = exp_wdata;
      end
      if (fwd_rs_idx == 0) m_hit = 1'b0;
      check("fwd_hit", fwd_hit, m_hit);
      if (m_hit) check("fwd_data", fwd_data, m_data);
    end
  end

  // driver tasks
  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    mul_wb_ex2_vld  = mv;
    mul_wb_ex2_rd   = mrd;
    mul_wb_ex2_data = md;
    lsu_wb_vld      = lv;
    lsu_wb_rd       = lrd;
    lsu_wb_data     = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  int fill_rd [7] = '{1, 2, 3, 3, 3, 3, 0};

  initial begin
    // reset then idle
    cpurst = 1'b1;
    tick();
    tick();
    cpurst = 1'b0;
    fwd_rs_idx = 5'd5;
    #1;
    check("rst_wen", wb_rf_wen, 1'b0);
    check("rst_waddr", wb_rf_waddr, 32'd0);
    check("rst_wdata", wb_rf_wdata, 32'd0);
    check("rst_stall", wb_xx_ex2_stall, 1'b0);
    check("rst_fwd_hit", fwd_hit, 1'b0);

    // direct path
    drive(1'b1, 5'd5, 32'h6, 1'b0, 5'd0, 32'h0);
    tick();
    check("direct_wen", wb_rf_wen, 1'b1);
    check("direct_waddr", wb_rf_waddr, 32'd5);
    check("direct_wdata", wb_rf_wdata, 32'h6);
    idle();
    tick();
    check("direct_wen_drop", wb_rf_wen, 1'b0);

    // collision: LSU first, multiply next cycle
    drive(1'b1, 5'd3, 32'hAAAA_0000, 1'b1, 5'd7, 32'h1234);
    tick();
    idle();
    check("coll_lsu_waddr", wb_rf_waddr, 32'd7);
    check("coll_lsu_wdata", wb_rf_wdata, 32'h1234);
    fwd_rs_idx = 5'd3;
    #1;
    check("coll_fwd_hit", fwd_hit, 1'b1);
    check("coll_fwd_data", fwd_data, 32'hAAAA_0000);
    tick();
    check("coll_mul_waddr", wb_rf_waddr, 32'd3);
    check("coll_mul_wdata", wb_rf_wdata, 32'hAAAA_0000);
    tick();
    check("coll_idle_wen", wb_rf_wen, 1'b0);

    // fill to full under LSU pressure, then drain in order
    for (int i = 0; i < 7; i++) begin
      drive(fill_rd[i] != 0, 5'(fill_rd[i]), 32'h100 + 32'(fill_rd[i]),
            i < 4, 5'(10 + i), 32'h200 + 32'(i));
      tick();
      if (i == 0) check("fill_lsu_waddr", wb_rf_waddr, 32'd10);
      if (i == 1 || i == 3) check("fill_stall", wb_xx_ex2_stall, 1'b1);
      if (i == 4) begin
        check("fill_pop1_waddr", wb_rf_waddr, 32'd1);
        check("fill_pop1_stall", wb_xx_ex2_stall, 1'b0);
      end
      if (i == 5) check("fill_pop2_wdata", wb_rf_wdata, 32'h102);
      if (i == 6) check("fill_pop3_waddr", wb_rf_waddr, 32'd3);
    end
    idle();
    tick();

    // forwarding priority: two buffered writes to r4
    drive(1'b1, 5'd4, 32'h11, 1'b1, 5'd9, 32'h99);
    tick();
    drive(1'b1, 5'd4, 32'h22, 1'b1, 5'd9, 32'h99);
    tick();
    idle();
    fwd_rs_idx = 5'd4;
    #1;
    check("fwdp_hit", fwd_hit, 1'b1);
    check("fwdp_data", fwd_data, 32'h22);
    fwd_rs_idx = 5'd0;
    #1;
    check("fwdp_x0_hit", fwd_hit, 1'b0);
    fwd_rs_idx = 5'd9;
    #1;
    check("fwdp_port_data", fwd_data, 32'h99);
    fwd_rs_idx = 5'd4;
    tick();
    tick();
    tick();

    // x0 drops
    drive(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    tick();
    check("x0_mul_wen", wb_rf_wen, 1'b0);
    drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77);
    tick();
    check("x0_lsu_wen", wb_rf_wen, 1'b0);
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
    tick();
    check("x0_after_direct", wb_rf_waddr, 32'd6);
    idle();
    tick();

    // reset with a full buffer
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd12, 32'h1);
    tick();
    drive(1'b1, 5'd9, 32'h89, 1'b1, 5'd12, 32'h1);
    tick();
    check("rmid_stall", wb_xx_ex2_stall, 1'b1);
    cpurst = 1'b1;
    drive(1'b1, 5'd10, 32'hA, 1'b1, 5'd13, 32'h2);
    tick();
    check("rmid_stall_clr", wb_xx_ex2_stall, 1'b0);
    check("rmid_wen", wb_rf_wen, 1'b0);
    cpurst = 1'b0;
    idle();
    tick();
    check("rmid_no_stale1", wb_rf_wen, 1'b0);
    tick();
    check("rmid_no_stale2", wb_rf_wen, 1'b0);

    // mixed traffic; a stalled multiply is held stable
    for (int i = 0; i < 300; i++) begin
      if (!(mul_wb_ex2_vld && exp_q_rd.size() == DEPTH)) begin
        mul_wb_ex2_vld  = ($urandom_range(0, 99) < 60);
        mul_wb_ex2_rd   = 5'($urandom_range(0, 7));
        mul_wb_ex2_data = $urandom;
      end
      lsu_wb_vld  = ($urandom_range(0, 99) < 40);
      lsu_wb_rd   = 5'($urandom_range(0, 7));
      lsu_wb_data = $urandom;
      fwd_rs_idx  = 5'($urandom_range(0, 7));
      tick();
    end
    idle();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
